// File: rtl/mem_bist_ctrl.sv
// Fill-and-verify BIST initiator for DataMemory: writes an LFSR pattern to every
// address, reads it back through a latency-aligned compare, and reports errors.
module mem_bist_ctrl #(
    parameter int         ADDR_W       = 10,
    parameter int         DATA_W       = 8,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_Start,
    output logic [ADDR_W-1:0] o_Address,
    output logic [DATA_W-1:0] o_WriteData,
    output logic              o_WriteEn,
    output logic              o_ReadEn,
    input  logic [DATA_W-1:0] i_ReadData,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Pass,
    output logic [ADDR_W:0]   o_ErrCount,
    output logic [ADDR_W-1:0] o_FirstErrAddr
);
    // state | meaning
    // IDLE  | after reset, waiting for i_Start
    // WRITE | one pattern write per cycle, address 0..DEPTH-1
    // READ  | one read per cycle, expected pattern regenerated from the seed
    // DRAIN | reads issued, waiting READ_LATENCY cycles for the last compares
    // DONE  | results valid and held, i_Start starts a new run

    localparam logic [DATA_W-1:0] SEED_EFF   = (SEED == 8'h00) ? DATA_W'(8'h01) : DATA_W'(SEED);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ERR_ONE    = (ADDR_W + 1)'(1);
    localparam logic [1:0]        DRAIN_LOAD = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state, stateNext;
    logic [DATA_W-1:0] pattern, patternNext;
    logic [ADDR_W-1:0] addrNext;
    logic              wrEnNext, rdEnNext, doneNext, passNext, busyNext, clearRes;
    logic [1:0]        drainCnt, drainNext;

    logic              alignedValid;
    logic [ADDR_W-1:0] alignedAddr;
    logic [DATA_W-1:0] alignedExp;
    logic              mismatch, finalPass;

    function automatic logic [DATA_W-1:0] lfsrStep(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Expected data/address follow the read through the same latency as the memory.
    if (READ_LATENCY == 0) begin : gNoDelay
        assign alignedValid = o_ReadEn;
        assign alignedAddr  = o_Address;
        assign alignedExp   = pattern;
    end else begin : gDelay
        logic              vPipe [READ_LATENCY];
        logic [ADDR_W-1:0] aPipe [READ_LATENCY];
        logic [DATA_W-1:0] ePipe [READ_LATENCY];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < READ_LATENCY; i++) begin
                    vPipe[i] <= 1'b0;
                    aPipe[i] <= '0;
                    ePipe[i] <= '0;
                end
            end else begin
                vPipe[0] <= o_ReadEn;
                aPipe[0] <= o_Address;
                ePipe[0] <= pattern;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vPipe[i] <= vPipe[i-1];
                    aPipe[i] <= aPipe[i-1];
                    ePipe[i] <= ePipe[i-1];
                end
            end
        end

        assign alignedValid = vPipe[READ_LATENCY-1];
        assign alignedAddr  = aPipe[READ_LATENCY-1];
        assign alignedExp   = ePipe[READ_LATENCY-1];
    end

    assign mismatch  = alignedValid && (i_ReadData != alignedExp);
    // The last compare lands in the same cycle DONE is entered, so fold it in here.
    assign finalPass = (o_ErrCount == '0) && !mismatch;

    always_comb begin
        stateNext   = state;
        patternNext = pattern;
        addrNext    = o_Address;
        wrEnNext    = 1'b0;
        rdEnNext    = 1'b0;
        doneNext    = o_Done;
        passNext    = o_Pass;
        drainNext   = drainCnt;
        clearRes    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (i_Start) begin
                    stateNext   = WRITE;
                    patternNext = SEED_EFF;
                    addrNext    = '0;
                    wrEnNext    = 1'b1;
                    doneNext    = 1'b0;
                    passNext    = 1'b0;
                    clearRes    = 1'b1;
                end
            end
            WRITE: begin
                if (o_Address == LAST_ADDR) begin
                    stateNext   = READ;
                    patternNext = SEED_EFF;
                    addrNext    = '0;
                    rdEnNext    = 1'b1;
                end else begin
                    patternNext = lfsrStep(pattern);
                    addrNext    = o_Address + ADDR_ONE;
                    wrEnNext    = 1'b1;
                end
            end
            READ: begin
                if (o_Address == LAST_ADDR) begin
                    addrNext = '0;
                    if (READ_LATENCY == 0) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                        passNext  = finalPass;
                    end else begin
                        stateNext = DRAIN;
                        drainNext = DRAIN_LOAD;
                    end
                end else begin
                    patternNext = lfsrStep(pattern);
                    addrNext    = o_Address + ADDR_ONE;
                    rdEnNext    = 1'b1;
                end
            end
            DRAIN: begin
                if (drainCnt == 2'd0) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                    passNext  = finalPass;
                end else begin
                    drainNext = drainCnt - 2'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext == WRITE) || (stateNext == READ) || (stateNext == DRAIN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            pattern     <= SEED_EFF;
            drainCnt    <= 2'd0;
            o_Address   <= '0;
            o_WriteData <= '0;
            o_WriteEn   <= 1'b0;
            o_ReadEn    <= 1'b0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Pass      <= 1'b0;
        end else begin
            state       <= stateNext;
            pattern     <= patternNext;
            drainCnt    <= drainNext;
            o_Address   <= addrNext;
            o_WriteData <= wrEnNext ? patternNext : '0;
            o_WriteEn   <= wrEnNext;
            o_ReadEn    <= rdEnNext;
            o_Busy      <= busyNext;
            o_Done      <= doneNext;
            o_Pass      <= passNext;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ErrCount     <= '0;
            o_FirstErrAddr <= '0;
        end else if (clearRes) begin
            o_ErrCount     <= '0;
            o_FirstErrAddr <= '0;
        end else if (mismatch) begin
            o_ErrCount <= o_ErrCount + ERR_ONE;
            if (o_ErrCount == '0) begin
                o_FirstErrAddr <= alignedAddr;
            end
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: three instances (read latency 1, 0, 3) share clock,
// reset and start; each has its own DataMemory model with injectable read faults.
module tb_mem_bist_ctrl;
    localparam int DEPTH = 1024;
    localparam int BUDGET = 5000;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  addr1, ferr1, addr0, ferr0, addr3, ferr3;
    logic [7:0]  wdata1, rdata1, wdata0, rdata0, wdata3, rdata3;
    logic        we1, re1, busy1, done1, pass1;
    logic        we0, re0, busy0, done0, pass0;
    logic        we3, re3, busy3, done3, pass3;
    logic [10:0] err1, err0, err3;

    mem_bist_ctrl #(.READ_LATENCY(1)) uL1 (
        .i_clk(clk), .i_rst_n(rstN), .i_Start(start), .o_Address(addr1), .o_WriteData(wdata1),
        .o_WriteEn(we1), .o_ReadEn(re1), .i_ReadData(rdata1), .o_Busy(busy1), .o_Done(done1),
        .o_Pass(pass1), .o_ErrCount(err1), .o_FirstErrAddr(ferr1));
    mem_bist_ctrl #(.READ_LATENCY(0)) uL0 (
        .i_clk(clk), .i_rst_n(rstN), .i_Start(start), .o_Address(addr0), .o_WriteData(wdata0),
        .o_WriteEn(we0), .o_ReadEn(re0), .i_ReadData(rdata0), .o_Busy(busy0), .o_Done(done0),
        .o_Pass(pass0), .o_ErrCount(err0), .o_FirstErrAddr(ferr0));
    mem_bist_ctrl #(.READ_LATENCY(3)) uL3 (
        .i_clk(clk), .i_rst_n(rstN), .i_Start(start), .o_Address(addr3), .o_WriteData(wdata3),
        .o_WriteEn(we3), .o_ReadEn(re3), .i_ReadData(rdata3), .o_Busy(busy3), .o_Done(done3),
        .o_Pass(pass3), .o_ErrCount(err3), .o_FirstErrAddr(ferr3));

    // Memory models; faultMask is XORed onto data read back from that address.
    logic [7:0] faultMask [DEPTH];
    logic [7:0] mem1 [DEPTH];
    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem3 [DEPTH];
    logic [7:0] p1, p2, p3;

    always @(posedge clk) begin
        if (we1) mem1[addr1] <= wdata1;
        if (re1) rdata1 <= mem1[addr1] ^ faultMask[addr1];
        if (we0) mem0[addr0] <= wdata0;
        if (we3) mem3[addr3] <= wdata3;
        p1 <= mem3[addr3] ^ faultMask[addr3];
        p2 <= p1;
        p3 <= p2;
    end
    assign rdata0 = mem0[addr0] ^ faultMask[addr0];
    assign rdata3 = p3;

    // Reference pattern: LFSR state after a shifts from the seed.
    logic [7:0] expPat [DEPTH];
    initial begin
        logic [7:0] s;
        s = 8'hA5;
        for (int a = 0; a < DEPTH; a++) begin
            expPat[a] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    end

    // Bus monitor on the latency-1 instance.
    int wrCount = 0, rdCount = 0, wrSeqErr = 0, rdSeqErr = 0, bothErr = 0;
    int expWr = 0, expRd = 0;
    always @(negedge clk) begin
        if (rstN) begin
            if (we1 && re1) bothErr <= bothErr + 1;
            if (!busy1) expWr <= 0;
            if (we1) begin
                expRd <= 0;
                wrCount <= wrCount + 1;
                if (int'(addr1) != expWr || wdata1 != expPat[addr1]) wrSeqErr <= wrSeqErr + 1;
                expWr <= int'(addr1) + 1;
            end
            if (re1) begin
                rdCount <= rdCount + 1;
                if (int'(addr1) != expRd) rdSeqErr <= rdSeqErr + 1;
                expRd <= int'(addr1) + 1;
            end
        end
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearFaults();
        for (int a = 0; a < DEPTH; a++) faultMask[a] = 8'h00;
    endtask

    task automatic runPass(input int midStart, output int d1, output int d0, output int d3);
        int n, w0, r0, ws0, rs0, b0;
        bit pulsed;
        d1 = -1; d0 = -1; d3 = -1; pulsed = 0;
        w0 = wrCount; r0 = rdCount; ws0 = wrSeqErr; rs0 = rdSeqErr; b0 = bothErr;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        check("start_state", {done1, err1, ferr1, busy1, we1, re1, addr1, wdata1},
              {1'b0, 11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 10'd0, 8'hA5});
        n = 1;
        while (n < BUDGET && (d1 < 0 || d0 < 0 || d3 < 0)) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 2) check("second_write", {we1, addr1, wdata1}, {1'b1, 10'd1, 8'h4A});
            if (d1 < 0 && done1) d1 = n;
            if (d0 < 0 && done0) d0 = n;
            if (d3 < 0 && done3) d3 = n;
            if (midStart >= 0 && !pulsed && we1 && int'(addr1) == midStart) begin
                start = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("write_count", wrCount - w0, DEPTH);
        check("read_count", rdCount - r0, DEPTH);
        check("write_sequence_errs", wrSeqErr - ws0, 0);
        check("read_sequence_errs", rdSeqErr - rs0, 0);
        check("both_enables", bothErr - b0, 0);
    endtask

    task automatic checkRun(input string tag, input int expErr, input int expFirst, input bit expPass,
                            input int d1, input int d0, input int d3);
        check({tag, "_done_cycle_L1"}, d1, 2050);
        check({tag, "_done_cycle_L0"}, d0, 2049);
        check({tag, "_done_cycle_L3"}, d3, 2052);
        check({tag, "_L1_result"}, {done1, pass1, err1, ferr1}, {1'b1, expPass, 11'(expErr), 10'(expFirst)});
        check({tag, "_L0_result"}, {done0, pass0, err0, ferr0}, {1'b1, expPass, 11'(expErr), 10'(expFirst)});
        check({tag, "_L3_result"}, {done3, pass3, err3, ferr3}, {1'b1, expPass, 11'(expErr), 10'(expFirst)});
        check({tag, "_L1_idle"}, {busy1, we1, re1}, 3'b000);
    endtask

    typedef struct {
        string      name;
        logic [9:0] a0;
        logic [7:0] m0;
        logic [9:0] a1;
        logic [7:0] m1;
        int         expErr;
        int         expFirst;
        bit         expPass;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int d1, d0, d3, nf, expErr, expFirst, n;
        bit found;
        vecs[0] = '{"clean",      10'h000, 8'h00, 10'h000, 8'h00, 0, 0,      1'b1};
        vecs[1] = '{"two_faults", 10'h155, 8'h08, 10'h2A0, 8'h08, 2, 'h155,  1'b0};
        vecs[2] = '{"addr0",      10'h000, 8'h01, 10'h000, 8'h00, 1, 0,      1'b0};
        vecs[3] = '{"last_addr",  10'h3FF, 8'h80, 10'h000, 8'h00, 1, 'h3FF,  1'b0};
        vecs[4] = '{"unordered",  10'h300, 8'hFF, 10'h005, 8'h10, 2, 5,      1'b0};
        clearFaults();

        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset_outputs", {addr1, wdata1, we1, re1, busy1, done1, pass1, err1, ferr1}, 0);
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", {addr1, wdata1, we1, re1, busy1, done1, pass1, err1, ferr1}, 0);
        end

        for (int v = 0; v < 5; v++) begin
            clearFaults();
            if (vecs[v].m0 != 0) faultMask[vecs[v].a0] = vecs[v].m0;
            if (vecs[v].m1 != 0) faultMask[vecs[v].a1] = vecs[v].m1;
            runPass(-1, d1, d0, d3);
            checkRun(vecs[v].name, vecs[v].expErr, vecs[v].expFirst, vecs[v].expPass, d1, d0, d3);
            if (v == 1) begin
                runPass(-1, d1, d0, d3);
                checkRun("restart_in_done", vecs[v].expErr, vecs[v].expFirst, vecs[v].expPass, d1, d0, d3);
            end
        end

        clearFaults();
        runPass(500, d1, d0, d3);
        checkRun("start_during_write", 0, 0, 1'b1, d1, d0, d3);

        for (int r = 0; r < 3; r++) begin
            clearFaults();
            nf = $urandom_range(1, 6);
            for (int k = 0; k < nf; k++) faultMask[$urandom_range(0, DEPTH - 1)] = 8'($urandom_range(1, 255));
            expErr = 0;
            expFirst = 0;
            for (int a = 0; a < DEPTH; a++) begin
                if (faultMask[a] != 0) begin
                    if (expErr == 0) expFirst = a;
                    expErr++;
                end
            end
            runPass(-1, d1, d0, d3);
            checkRun("random", expErr, expFirst, expErr == 0, d1, d0, d3);
        end

        clearFaults();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (re1 && addr1 == 10'd300) found = 1;
        end
        check("reach_read_300", found, 1'b1);
        #1 rstN = 1'b0;
        #1 check("async_reset_drop", {re1, we1, busy1, done1, addr1, err1}, 0);
        @(negedge clk) rstN = 1'b1;
        @(negedge clk);
        check("after_reset_idle", {busy1, done1, re1, we1}, 4'b0000);
        runPass(-1, d1, d0, d3);
        checkRun("after_reset", 0, 0, 1'b1, d1, d0, d3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
